// File: rtl/st_ld_fwd_buffer.sv
`default_nettype none
// ============================================================================
// Module      : st_ld_fwd_buffer
// Description : In-order store buffer draining to data memory, with
//               youngest-first store-to-load forwarding for the MEM stage.
// Revision    : 1.0
// ============================================================================
module st_ld_fwd_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       mem_wr_valid,
    input  logic                       mem_wr_ready,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic [DATA_W-1:0]          mem_wr_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_enq;
    logic              w_deq;
    logic [PTR_W-1:0]  w_age [DEPTH];
    logic [DEPTH-1:0]  w_match;
    logic [PTR_W-1:0]  w_idx;
    logic              w_ld_hit;
    logic [DATA_W-1:0] w_ld_data;

    assign st_ready     = (r_count != C_FULL_COUNT);
    assign empty        = (r_count == '0);
    assign count        = r_count;
    assign mem_wr_valid = !empty;
    assign mem_wr_addr  = r_addr[r_head];
    assign mem_wr_data  = r_data[r_head];

    assign w_enq = st_valid && st_ready;
    assign w_deq = mem_wr_valid && mem_wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + C_PTR_ONE;
            end
            if (w_deq) begin
                r_head <= r_head + C_PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: occupancy is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
    end

    // An entry is live when its age (distance from head) is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_age[g]   = PTR_W'(g) - r_head;
        assign w_match[g] = ld_valid
                         && ({1'b0, w_age[g]} < r_count)
                         && (r_addr[g][ADDR_W-1:3] == ld_addr[ADDR_W-1:3]);
    end

    // Walk oldest to youngest so the youngest match overwrites; the store
    // being accepted this cycle is younger than every buffered entry.
    always_comb begin
        w_ld_hit  = 1'b0;
        w_ld_data = '0;
        w_idx     = '0;
        for (int a = 0; a < DEPTH; a++) begin
            w_idx = r_head + PTR_W'(a);
            if (w_match[w_idx]) begin
                w_ld_hit  = 1'b1;
                w_ld_data = r_data[w_idx];
            end
        end
        if (ld_valid && w_enq && (st_addr[ADDR_W-1:3] == ld_addr[ADDR_W-1:3])) begin
            w_ld_hit  = 1'b1;
            w_ld_data = st_data;
        end
    end

    assign ld_hit  = w_ld_hit;
    assign ld_data = w_ld_data;

endmodule
`default_nettype wire

// File: tb/tb_st_ld_fwd_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_st_ld_fwd_buffer
// Description : Self-checking bench for st_ld_fwd_buffer (table, sequences,
//               randomized traffic against a queue-based reference model).
// Revision    : 1.0
// ============================================================================
module tb_st_ld_fwd_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        ld_valid;
    logic [63:0] ld_addr;
    logic        ld_hit;
    logic [63:0] ld_data;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [63:0] mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq_addr [$];
    logic [63:0] mq_data [$];

    st_ld_fwd_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .ld_data      (ld_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .count        (count),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        sv;
        logic [63:0] sa;
        logic [63:0] sd;
        logic        lv;
        logic [63:0] la;
        logic        rdy;
        logic        e_hit;
        logic [63:0] e_data;
        int          e_cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: youngest matching store wins; an accepted incoming store is youngest.
    function automatic void mfwd(output logic hit, output logic [63:0] data);
        hit  = 1'b0;
        data = '0;
        if (ld_valid) begin
            if (st_valid && mq_addr.size() < DEPTH && st_addr[63:3] == ld_addr[63:3]) begin
                hit  = 1'b1;
                data = st_data;
            end else begin
                for (int i = mq_addr.size() - 1; i >= 0; i--) begin
                    if (mq_addr[i][63:3] == ld_addr[63:3]) begin
                        hit  = 1'b1;
                        data = mq_data[i];
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic check_model();
        logic        h;
        logic [63:0] d;
        int          n;
        n = mq_addr.size();
        mfwd(h, d);
        chk("st_ready", 64'(st_ready), 64'(n < DEPTH));
        chk("ld_hit", 64'(ld_hit), 64'(h));
        chk("ld_data", ld_data, d);
        chk("mem_wr_valid", 64'(mem_wr_valid), 64'(n > 0));
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        if (n > 0) begin
            chk("mem_wr_addr", mem_wr_addr, mq_addr[0]);
            chk("mem_wr_data", mem_wr_data, mq_data[0]);
        end
    endtask

    task automatic model_step();
        bit enq;
        bit deq;
        enq = st_valid && (mq_addr.size() < DEPTH);
        deq = (mq_addr.size() > 0) && mem_wr_ready;
        if (deq) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
        end
        if (enq) begin
            mq_addr.push_back(st_addr);
            mq_data.push_back(st_data);
        end
    endtask

    // Called ~2 time units after inputs change; advances to posedge+1.
    task automatic tick();
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                         input logic lv, input logic [63:0] la, input logic rdy);
        st_valid     = sv;
        st_addr      = sa;
        st_data      = sd;
        ld_valid     = lv;
        ld_addr      = la;
        mem_wr_ready = rdy;
    endtask

    initial begin
        int sent;
        int drained;
        logic [63:0] ra;
        logic [63:0] la;

        tbl[0]  = '{1'b1, 64'h200, 64'hAA, 1'b1, 64'h200, 1'b0, 1'b1, 64'hAA, 0};
        tbl[1]  = '{1'b1, 64'h200, 64'hBB, 1'b1, 64'h204, 1'b0, 1'b1, 64'hBB, 1};
        tbl[2]  = '{1'b0, 64'h0,   64'h0,  1'b1, 64'h204, 1'b0, 1'b1, 64'hBB, 2};
        tbl[3]  = '{1'b1, 64'h300, 64'h11, 1'b1, 64'h400, 1'b0, 1'b0, 64'h0,  2};
        tbl[4]  = '{1'b1, 64'h300, 64'hCC, 1'b1, 64'h300, 1'b0, 1'b1, 64'hCC, 3};
        tbl[5]  = '{1'b0, 64'h0,   64'h0,  1'b0, 64'h300, 1'b0, 1'b0, 64'h0,  4};
        tbl[6]  = '{1'b1, 64'h500, 64'hDD, 1'b1, 64'h500, 1'b0, 1'b0, 64'h0,  4};
        tbl[7]  = '{1'b0, 64'h0,   64'h0,  1'b1, 64'h200, 1'b1, 1'b1, 64'hBB, 4};
        tbl[8]  = '{1'b0, 64'h0,   64'h0,  1'b1, 64'h200, 1'b1, 1'b1, 64'hBB, 3};
        tbl[9]  = '{1'b0, 64'h0,   64'h0,  1'b1, 64'h200, 1'b1, 1'b0, 64'h0,  2};
        tbl[10] = '{1'b0, 64'h0,   64'h0,  1'b1, 64'h300, 1'b1, 1'b1, 64'hCC, 1};
        tbl[11] = '{1'b0, 64'h0,   64'h0,  1'b1, 64'h300, 1'b0, 1'b0, 64'h0,  0};

        // Power-on reset
        rst_n = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0);
        #3;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_st_ready", 64'(st_ready), 64'd1);
        chk("reset_mem_wr_valid", 64'(mem_wr_valid), 64'd0);
        chk("reset_ld_hit", 64'(ld_hit), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Forwarding priority, miss, ld_valid gating, full rejection
        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].sv, tbl[k].sa, tbl[k].sd, tbl[k].lv, tbl[k].la, tbl[k].rdy);
            #2;
            chk($sformatf("tbl%0d_ld_hit", k), 64'(ld_hit), 64'(tbl[k].e_hit));
            chk($sformatf("tbl%0d_ld_data", k), ld_data, tbl[k].e_data);
            chk($sformatf("tbl%0d_count", k), 64'(count), 64'(tbl[k].e_cnt));
            tick();
        end

        // Fill with memory stalled, reject a fifth store, then drain in order
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 64'h100 + 64'(8 * k), 64'hF000 + 64'(k), 1'b0, 64'h0, 1'b0);
            #2;
            chk($sformatf("fill%0d_st_ready", k), 64'(st_ready), 64'(k < 4));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1);
            #2;
            chk($sformatf("drain%0d_addr", k), mem_wr_addr, 64'h100 + 64'(8 * k));
            chk($sformatf("drain%0d_count", k), 64'(count), 64'(4 - k));
            tick();
        end

        // Saturated traffic with wrap-around: occupancy steady, order preserved
        sent    = 0;
        drained = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 64'h1000 + 64'(8 * sent), 64'hC000 + 64'(sent), 1'b0, 64'h0, 1'b0);
            #2;
            tick();
            sent++;
        end
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 64'h1000 + 64'(8 * sent), 64'hC000 + 64'(sent), 1'b1,
                  64'h1000 + 64'(8 * $urandom_range(0, 15)), 1'b1);
            #2;
            chk($sformatf("wrap%0d_count", c), 64'(count), (c == 0) ? 64'd4 : 64'd3);
            chk($sformatf("wrap%0d_addr", c), mem_wr_addr, 64'h1000 + 64'(8 * drained));
            chk($sformatf("wrap%0d_data", c), mem_wr_data, 64'hC000 + 64'(drained));
            if (mq_addr.size() < DEPTH) sent++;
            drained++;
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1);
            #2;
            chk($sformatf("wrapend%0d_addr", c), mem_wr_addr, 64'h1000 + 64'(8 * drained));
            drained++;
            tick();
        end

        // Randomized traffic over a small address pool to provoke aliasing
        for (int c = 0; c < 300; c++) begin
            ra = 64'h800 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
            la = 64'h800 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), ra, {$urandom, $urandom},
                  1'($urandom_range(0, 3) != 0), la, 1'($urandom_range(0, 2) != 0));
            #2;
            tick();
        end

        // Drain, load three stores, then reset mid-traffic
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1);
            #2;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 64'h600 + 64'(8 * k), 64'h6600 + 64'(k), 1'b0, 64'h0, 1'b0);
            #2;
            tick();
        end
        drive(1'b0, 64'h0, 64'h0, 1'b1, 64'h600, 1'b0);
        #1;
        chk("pre_reset_count", 64'(count), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_empty", 64'(empty), 64'd1);
        chk("midreset_mem_wr_valid", 64'(mem_wr_valid), 64'd0);
        chk("midreset_ld_hit", 64'(ld_hit), 64'd0);
        mq_addr.delete();
        mq_data.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reuse after reset
        drive(1'b1, 64'h700, 64'h77, 1'b0, 64'h0, 1'b0);
        #2;
        tick();
        drive(1'b0, 64'h0, 64'h0, 1'b1, 64'h703, 1'b0);
        #2;
        chk("reuse_ld_hit", 64'(ld_hit), 64'd1);
        chk("reuse_ld_data", ld_data, 64'h77);
        chk("reuse_count", 64'(count), 64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
